// File: rtl/md_ctrl.sv
// Multiply/divide sequencer for the MIPS pipeline: issues md-class ops, holds the
// result for a fixed latency, then commits it to HI/LO and serves mfhi/mflo reads.
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8,
        OP_MTHI  = 4'd9,
        OP_MTLO  = 4'd10,
        OP_MFHI  = 4'd11,
        OP_MFLO  = 4'd12
    } md_op_e;

    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [31:0]   r_phi;
    logic [31:0]   r_plo;
    logic          r_pvalid;
    logic [CW-1:0] r_cnt;

    logic          w_is_md;
    logic          w_is_div;
    logic          w_accept;
    logic          w_divzero;
    logic [CW-1:0] w_load;
    logic [63:0]   w_hilo;
    logic [63:0]   w_sprod;
    logic [63:0]   w_uprod;
    logic [63:0]   w_res;

    logic          w_a_neg;
    logic          w_b_neg;
    logic [31:0]   w_a_mag;
    logic [31:0]   w_b_mag;
    logic [31:0]   w_sdiv_b;
    logic [31:0]   w_udiv_b;
    logic [31:0]   w_sq_mag;
    logic [31:0]   w_sr_mag;
    logic [31:0]   w_sq;
    logic [31:0]   w_sr;
    logic [31:0]   w_uq;
    logic [31:0]   w_ur;

    assign w_is_md   = (op >= OP_MULT) && (op <= OP_MSUBU);
    assign w_is_div  = (op == OP_DIV) || (op == OP_DIVU);
    assign w_accept  = start && (op >= OP_MULT) && (op <= OP_MTLO) && (r_cnt == '0);
    assign w_divzero = w_is_div && (b == 32'd0);
    assign w_load    = w_is_div ? DIV_LOAD : MULT_LOAD;
    assign w_hilo    = {r_hi, r_lo};

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign w_sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_uprod = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
    assign w_a_neg  = a[31];
    assign w_b_neg  = b[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - a) : a;
    assign w_b_mag  = w_b_neg ? (32'd0 - b) : b;
    assign w_sdiv_b = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_udiv_b = (b == 32'd0) ? 32'd1 : b;
    assign w_sq_mag = w_a_mag / w_sdiv_b;
    assign w_sr_mag = w_a_mag % w_sdiv_b;
    assign w_sq     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_sq_mag) : w_sq_mag;
    assign w_sr     = w_a_neg ? (32'd0 - w_sr_mag) : w_sr_mag;
    assign w_uq     = a / w_udiv_b;
    assign w_ur     = a % w_udiv_b;

    always_comb begin
        w_res = 64'd0;
        case (op)
            OP_MULT:  w_res = w_sprod;
            OP_MULTU: w_res = w_uprod;
            OP_DIV:   w_res = {w_sr, w_sq};
            OP_DIVU:  w_res = {w_ur, w_uq};
            OP_MADD:  w_res = w_hilo + w_sprod;
            OP_MADDU: w_res = w_hilo + w_uprod;
            OP_MSUB:  w_res = w_hilo - w_sprod;
            OP_MSUBU: w_res = w_hilo - w_uprod;
            default:  w_res = 64'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_phi    <= 32'd0;
            r_plo    <= 32'd0;
            r_pvalid <= 1'b0;
            r_cnt    <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
                r_pvalid <= 1'b0;
                if (r_pvalid) begin
                    r_hi <= r_phi;
                    r_lo <= r_plo;
                end
            end
        end else if (w_accept) begin
            if (w_is_md) begin
                r_phi    <= w_res[63:32];
                r_plo    <= w_res[31:0];
                r_pvalid <= !w_divzero;
                r_cnt    <= w_load;
            end else if (op == OP_MTHI) begin
                r_hi <= a;
            end else begin
                r_lo <= a;
            end
        end
    end

    // Issue-cycle term makes the D stage stall before the counter is loaded.
    assign busy  = (start && w_is_md) || (r_cnt != '0);
    assign stall = d_md && busy;
    assign hi    = r_hi;
    assign lo    = r_lo;

    always_comb begin
        rdata = 32'd0;
        if (op == OP_MFHI) begin
            rdata = r_hi;
        end else if (op == OP_MFLO) begin
            rdata = r_lo;
        end
    end

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Sequencing controller for the shared multiply/divide resource in the pipelined MIPS core. It accepts md-class operations from the E stage, runs them for a fixed multi-cycle latency and commits results to the architectural HI/LO registers. It serves mfhi/mflo reads and drives the D-stage stall for any md-class instruction that arrives while the unit is busy. The ID stage tags these instructions with its `md` flag.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  E-stage instruction is a valid md-class op this cycle
- op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu, 7 msub, 8 msubu, 9 mthi, 10 mtlo, 11 mfhi, 12 mflo
- a  in  32  forwarded rs value
- b  in  32  forwarded rt value
- d_md  in  1  D-stage instruction is md-class (ID `md` flag)
- busy  out  1  unit occupied
- stall  out  1  stall request to D stage
- hi  out  32  HI register
- lo  out  32  LO register
- rdata  out  32  mfhi/mflo result

## Operation
- State: hi, lo, cnt (width to hold max(MULT_CYCLES, DIV_CYCLES)), pending result {phi, plo}, pending-valid flag.
- An op is accepted on a rising edge when start=1, op∈1..10 and cnt==0. If start=1 while cnt≠0, the op is ignored and no state changes (the stall contract makes this unreachable).
- Ops 1–8, on acceptance:
  - Compute the full result from a, b and the current hi/lo.
  - Store it in {phi, plo} and load cnt with MULT_CYCLES or DIV_CYCLES.
- mult/multu: {phi,plo} = 64-bit signed/unsigned a*b.
- madd(u)/msub(u): {phi,plo} = {hi,lo} ± 64-bit signed/unsigned a*b, mod 2^64.
- div: plo = quotient truncated toward zero; phi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives plo=0x80000000, phi=0.
- divu: unsigned quotient and remainder.
- Divide by zero (b==0, ops 3/4): cnt is still loaded with DIV_CYCLES. At commit, hi/lo stay unchanged.
- mthi/mtlo: write a into hi/lo at the accepting edge. cnt stays 0 and busy is never raised by these ops.
- Commit: on the edge where cnt goes 1→0, hi/lo ← {phi,plo} unless the pending op was a divide by zero.
- cnt decrements on every edge while non-zero.
- rdata (combinational): hi when op==11, lo when op==12, else 0.
  - mfhi/mflo in the cycle after a commit edge read the committed value.
- busy = (start & op∈1..8) | (cnt≠0). The combinational term covers the issue cycle.
- stall = d_md & busy.
- Reset (asynchronous, any time including mid-operation): hi=lo=0, cnt=0, pending cleared. busy, stall and rdata follow combinationally, so they read 0 unless inputs drive them. An in-flight op is discarded.

## Timing
- Issue in cycle 0 (start sampled at the edge ending cycle 0). cnt=N during cycles 1..N.
- Commit occurs at the edge ending cycle N. New hi/lo are visible from cycle N+1, where busy=0.
- busy is high for cycles 0..N, i.e. N+1 cycles.
- mthi/mtlo in cycle 0 give new hi/lo from cycle 1.
- Back-to-back: a new op may issue in cycle N+1. It sees the committed hi/lo, which matters for madd chains.
- No combinational path from a/b to busy/stall. The only start/op → busy/stall path is the issue term.

## Test plan
- Reset: hold rst_n=0 → hi=lo=0, busy=0. Issue mult 3×4, assert rst_n=0 at cycle 2 → hi=lo=0 and busy=0 immediately; after release, cnt=0.
- mult 0xFFFFFFFF × 2 (signed) → busy high cycles 0..5; cycle 6 hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands → hi=1, lo=0xFFFFFFFE.
- div -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF at cycle 11. div 0x80000000/-1 → lo=0x80000000, hi=0. divu 7/0 → hi/lo unchanged, busy still 11 cycles.
- madd: mtlo 5, mthi 0, then madd 3×4 → lo=17; msubu 0×0 → unchanged. maddu with {hi,lo}=0xFFFFFFFF_FFFFFFFF plus 1×1 → wraps to 0.
- Stall: d_md=1 during cycles 0..5 of a mult → stall=1 exactly those cycles, 0 in cycle 6. start while busy → ignored, hi/lo untouched.
- mthi 0xA5A5A5A5 followed next cycle by mfhi → rdata=0xA5A5A5A5, busy never asserted.
